// File: rtl/hazard_muldiv_ctrl.sv
// Load-use hazard detection and scheduling of the shared iterative mul/div unit.
// Stalls PC and IF/ID and bubbles ID/EX while a HI/LO consumer waits on the busy unit.
module hazard_muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       memReadEX,
  input  logic [4:0] dstEX,
  input  logic [4:0] rsID,
  input  logic [4:0] rtID,
  input  logic       useRsID,
  input  logic       useRtID,
  input  logic       mdReqEX,
  input  logic [1:0] mdOpEX,
  input  logic       divisorZeroEX,
  input  logic       hiloUseID,
  output logic       stallPC,
  output logic       stallIFID,
  output logic       bubbleIDEX,
  output logic       mdStart,
  output logic [1:0] mdOp,
  output logic       mdBusy,
  output logic       hiloWe,
  output logic       divByZero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // The counter holds the number of BUSY cycles still to come after the current one.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [1:0] md_op_q, md_op_d;
  logic       dbz_q, dbz_d;
  logic       md_start_s;
  logic       load_use_s;
  logic       md_stall_s;
  logic       stall_s;

  // Hazard detection: register 0 never carries a real dependency.
  always_comb begin
    load_use_s = memReadEX && (dstEX != 5'd0) &&
                 ((useRsID && (rsID == dstEX)) || (useRtID && (rtID == dstEX)));
    md_stall_s = hiloUseID && (state_q == BUSY);
    stall_s    = load_use_s || md_stall_s;
  end

  // Next-state logic for the mul/div sequencer; requests outside IDLE are ignored.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    md_op_d    = md_op_q;
    dbz_d      = dbz_q;
    md_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdReqEX) begin
          md_start_s = 1'b1;
          state_d    = BUSY;
          md_op_d    = mdOpEX;
          count_d    = mdOpEX[1] ? DIV_LOAD : MULT_LOAD;
          dbz_d      = mdOpEX[1] && divisorZeroEX;
        end else begin
          state_d    = IDLE;
        end
      end
      BUSY: begin
        if (count_q == 6'd0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 6'd0;
      md_op_q <= 2'b00;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      md_op_q <= md_op_d;
      dbz_q   <= dbz_d;
    end
  end

  assign stallPC    = stall_s;
  assign stallIFID  = stall_s;
  assign bubbleIDEX = stall_s;
  assign mdStart    = md_start_s;
  assign mdOp       = md_op_q;
  assign mdBusy     = (state_q == BUSY);
  assign hiloWe     = (state_q == DONE);
  assign divByZero  = dbz_q;

endmodule

// File: tb/tb_hazard_muldiv_ctrl.sv
// Self-checking bench for hazard_muldiv_ctrl: hazard vector table, directed
// multi-cycle sequences, and a randomized run against a cycle-index reference model.
module tb_hazard_muldiv_ctrl;

  logic       clk;
  logic       rst_n;
  logic       memReadEX;
  logic [4:0] dstEX;
  logic [4:0] rsID;
  logic [4:0] rtID;
  logic       useRsID;
  logic       useRtID;
  logic       mdReqEX;
  logic [1:0] mdOpEX;
  logic       divisorZeroEX;
  logic       hiloUseID;
  logic       stallPC;
  logic       stallIFID;
  logic       bubbleIDEX;
  logic       mdStart;
  logic [1:0] mdOp;
  logic       mdBusy;
  logic       hiloWe;
  logic       divByZero;

  int total = 0;
  int bad   = 0;

  hazard_muldiv_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .memReadEX(memReadEX), .dstEX(dstEX), .rsID(rsID), .rtID(rtID),
    .useRsID(useRsID), .useRtID(useRtID),
    .mdReqEX(mdReqEX), .mdOpEX(mdOpEX), .divisorZeroEX(divisorZeroEX),
    .hiloUseID(hiloUseID),
    .stallPC(stallPC), .stallIFID(stallIFID), .bubbleIDEX(bubbleIDEX),
    .mdStart(mdStart), .mdOp(mdOp), .mdBusy(mdBusy), .hiloWe(hiloWe),
    .divByZero(divByZero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       mr;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       hilo;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk(name, {29'd0, stallPC, stallIFID, bubbleIDEX}, {29'd0, exp, exp, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    memReadEX = 1'b0; dstEX = 5'd0; rsID = 5'd0; rtID = 5'd0;
    useRsID = 1'b0; useRtID = 1'b0; mdReqEX = 1'b0; mdOpEX = 2'b00;
    divisorZeroEX = 1'b0; hiloUseID = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // mult from IDLE: 4 busy cycles, then one hiloWe cycle, then back to IDLE.
  task automatic run_mult(input string tag);
    mdReqEX = 1'b1; mdOpEX = 2'b00;
    #1 chk({tag, "_start"}, 32'(mdStart), 32'd1);
    step();
    mdReqEX = 1'b0;
    chk({tag, "_op"}, 32'(mdOp), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 32'(mdBusy), 32'd1);
      chk({tag, "_we_early"}, 32'(hiloWe), 32'd0);
      step();
    end
    chk({tag, "_we"}, 32'(hiloWe), 32'd1);
    chk({tag, "_busy_done"}, 32'(mdBusy), 32'd0);
    step();
    chk({tag, "_we_after"}, 32'(hiloWe), 32'd0);
  endtask

  int   cyc;
  int   start_cyc;
  int   n_cyc;
  bit   active;
  logic [1:0] exp_op;
  logic exp_dbz;

  initial begin
    // Hazard table: applied with the sequencer idle, so only load-use matters.
    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd7,  5'd0,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd7,  5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 5'd9,  5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd9,  5'd8,  5'd10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 5'd3,  5'd3,  5'd4,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 5'd12, 5'd1,  5'd12, 1'b1, 1'b1, 1'b1, 1'b1};

    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_busy", 32'(mdBusy), 32'd0);
    chk("rst_we", 32'(hiloWe), 32'd0);
    chk("rst_op", 32'(mdOp), 32'd0);
    chk("rst_dbz", 32'(divByZero), 32'd0);
    chk_stall("rst_stall", 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      memReadEX = vecs[i].mr; dstEX = vecs[i].dst; rsID = vecs[i].rs; rtID = vecs[i].rt;
      useRsID = vecs[i].urs; useRtID = vecs[i].urt; hiloUseID = vecs[i].hilo;
      #1 chk_stall($sformatf("vec%0d_stall", i), vecs[i].exp_stall);
      step();
    end
    clear_inputs();

    run_mult("mult");

    // divu with zero divisor, a stalled HI/LO consumer, and an illegal request mid-BUSY.
    mdReqEX = 1'b1; mdOpEX = 2'b11; divisorZeroEX = 1'b1;
    #1 chk("divu_start", 32'(mdStart), 32'd1);
    step();
    mdReqEX = 1'b0; divisorZeroEX = 1'b0; hiloUseID = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        mdReqEX = 1'b1; mdOpEX = 2'b00;
      end
      #1;
      chk("divu_busy", 32'(mdBusy), 32'd1);
      chk_stall("divu_md_stall", 1'b1);
      if (i == 5) chk("divu_ignored_req", 32'(mdStart), 32'd0);
      step();
      mdReqEX = 1'b0;
    end
    chk("divu_we", 32'(hiloWe), 32'd1);
    chk_stall("divu_done_release", 1'b0);
    chk("divu_dbz", 32'(divByZero), 32'd1);
    chk("divu_op", 32'(mdOp), 32'd3);
    step();
    hiloUseID = 1'b0;
    chk("divu_idle_we", 32'(hiloWe), 32'd0);
    chk("divu_dbz_hold", 32'(divByZero), 32'd1);
    run_mult("mult_clear");
    chk("dbz_cleared", 32'(divByZero), 32'd0);

    // Reset in the 10th BUSY cycle of a div aborts it.
    mdReqEX = 1'b1; mdOpEX = 2'b10; divisorZeroEX = 1'b1;
    step();
    mdReqEX = 1'b0; divisorZeroEX = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("abort_pre_busy", 32'(mdBusy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(mdBusy), 32'd0);
    chk("abort_dbz", 32'(divByZero), 32'd0);
    chk("abort_we", 32'(hiloWe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (hiloWe !== 1'b0 || mdBusy !== 1'b0)
        chk("abort_quiet", {30'd0, hiloWe, mdBusy}, 32'd0);
    end
    total++;
    run_mult("mult_after_abort");

    // Randomized run against a cycle-index model of the sequencer.
    clear_inputs();
    do_reset();
    cyc = 0; active = 1'b0; start_cyc = 0; n_cyc = 0; exp_op = 2'b00; exp_dbz = 1'b0;
    for (int k = 0; k < 600; k++) begin
      int  el;
      bit  e_busy, e_done, e_idle, e_lu;
      el     = cyc - start_cyc;
      e_busy = active && el >= 1 && el <= n_cyc;
      e_done = active && el == n_cyc + 1;
      e_idle = !e_busy && !e_done;
      memReadEX = 1'($urandom_range(0, 1)); dstEX = 5'($urandom_range(0, 3));
      rsID = 5'($urandom_range(0, 3)); rtID = 5'($urandom_range(0, 3));
      useRsID = 1'($urandom_range(0, 1)); useRtID = 1'($urandom_range(0, 1));
      mdReqEX = ($urandom_range(0, 3) == 0); mdOpEX = 2'($urandom_range(0, 3));
      divisorZeroEX = 1'($urandom_range(0, 1)); hiloUseID = 1'($urandom_range(0, 1));
      e_lu = memReadEX && dstEX != 5'd0 &&
             ((useRsID && rsID == dstEX) || (useRtID && rtID == dstEX));
      #1;
      chk_stall("rnd_stall", e_lu || (hiloUseID && e_busy));
      chk("rnd_start", 32'(mdStart), 32'(e_idle && mdReqEX));
      chk("rnd_busy", 32'(mdBusy), 32'(e_busy));
      chk("rnd_we", 32'(hiloWe), 32'(e_done));
      chk("rnd_op", 32'(mdOp), 32'(exp_op));
      chk("rnd_dbz", 32'(divByZero), 32'(exp_dbz));
      if (e_idle && mdReqEX) begin
        active = 1'b1; start_cyc = cyc; n_cyc = mdOpEX[1] ? 32 : 4;
        exp_op = mdOpEX; exp_dbz = mdOpEX[1] && divisorZeroEX;
      end
      step();
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_muldiv_ctrl.md
# hazard_muldiv_ctrl

Pipeline hazard and multi-cycle scheduler for the five-stage CPU. Detects load-use hazards between ID and EX that forwarding cannot cover, and sequences the shared iterative multiply/divide unit. It stalls PC and IF/ID and injects bubbles into ID/EX while a HI/LO-dependent instruction waits. It sits beside the EX forwarding logic and drives the pipeline-register enables and the mul/div datapath's start/op/write-enable.

## Interface
- MULT_CYCLES, 4, busy cycles for mult/multu (1..63)
- DIV_CYCLES, 32, busy cycles for div/divu (1..63)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- memReadEX  input  1  EX-stage instruction is a load
- dstEX  input  5  EX-stage destination register
- rsID  input  5  ID-stage rs field
- rtID  input  5  ID-stage rt field
- useRsID  input  1  ID instruction reads rs
- useRtID  input  1  ID instruction reads rt
- mdReqEX  input  1  EX-stage instruction is mult/multu/div/divu
- mdOpEX  input  2  00 mult, 01 multu, 10 div, 11 divu
- divisorZeroEX  input  1  rt operand in EX is zero
- hiloUseID  input  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu
- stallPC  output  1  hold PC
- stallIFID  output  1  hold IF/ID register
- bubbleIDEX  output  1  load NOP into ID/EX
- mdStart  output  1  one-cycle start to the mul/div datapath
- mdOp  output  2  op latched at start
- mdBusy  output  1  unit is computing
- hiloWe  output  1  write HI/LO from the unit's result
- divByZero  output  1  sticky flag: last started divide had zero divisor

## Operation
- loadUse = memReadEX && dstEX != 0 && ((useRsID && rsID == dstEX) || (useRtID && rtID == dstEX)).
- mdStall = hiloUseID && state == BUSY.
- stallPC = stallIFID = bubbleIDEX = loadUse || mdStall. All three are combinational.
- The FSM has three states: IDLE, BUSY, DONE.
  - IDLE: mdStart = mdReqEX (combinational). On an edge with mdReqEX: latch mdOp = mdOpEX and count = (mdOpEX[1] ? DIV_CYCLES : MULT_CYCLES) − 1. Set divByZero = mdOpEX[1] && divisorZeroEX. Go to BUSY.
  - BUSY: mdBusy = 1. If count == 0, go to DONE; else count decrements by 1.
  - DONE: hiloWe = 1 for exactly this cycle, then IDLE. mdBusy = 0. No stall from this state.
- mdReqEX in BUSY or DONE is a protocol violation: ignore it, with no start and no state change. It cannot occur in normal flow because of mdStall.
- Count is 6 bits unsigned and never wraps. The decrement happens only when count is nonzero.
- divByZero holds until the next accepted start. The unit still runs the full DIV_CYCLES and hiloWe still pulses; HI/LO content is the datapath's concern.
- Simultaneous loadUse and mdStall give a single stall; the outputs are ORed.

## Timing
- Reset (async, immediate):
  - state = IDLE, count = 0, mdOp = 00, divByZero = 0.
  - mdBusy = 0, hiloWe = 0.
  - mdStart and stall outputs follow their combinational inputs with state IDLE.
- Latency from an accepted start to the hiloWe cycle is N+1 edges. N = MULT_CYCLES or DIV_CYCLES; BUSY lasts exactly N cycles, then one DONE cycle.
- The next start is accepted earliest in the cycle after DONE, in IDLE.
- Reset asserted mid-BUSY aborts the operation: no hiloWe pulse, and divByZero clears.
- A stalled hilo instruction in ID is released in the DONE cycle. It enters EX in the following cycle, after the HI/LO write edge.

## Test plan
- Load-use: memReadEX = 1, dstEX = 5, rsID = 5, useRsID = 1 -> stallPC, stallIFID and bubbleIDEX all = 1 that cycle. Changing dstEX to 0 -> all 0.
- No false hazard: memReadEX = 1, dstEX = 7, rtID = 7, useRtID = 0 -> no stall.
- mult: mdReqEX = 1, mdOpEX = 00 in IDLE -> mdStart = 1. mdBusy = 1 for 4 cycles, then hiloWe = 1 for 1 cycle. mdOp = 00.
- divu with divisorZeroEX = 1 -> mdBusy for 32 cycles, hiloWe on the 33rd cycle after the start edge. divByZero = 1 until the next start, which clears it.
- mfhi in ID (hiloUseID = 1) during BUSY -> stall every BUSY cycle. Stall drops in DONE. A mdReqEX injected during BUSY -> ignored, with no mdStart.
- Drop rst_n on the 10th BUSY cycle of a div -> immediate IDLE, mdBusy = 0, no hiloWe. A new mult after release completes normally in 4+1 cycles.
